// File: rtl/kb_array.sv
// kb_array: WIDTH KB flip-flop cells sharing clock and reset, with KB/COUNT/SHIFT/HOLD modes,
// adjacent-bit equality, wrap pulse and saturating change counter. Optional par output: KB_ARRAY_PARITY_EN.
module kb_array #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] b,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-2:0] z,
  output logic             wrap,
  output logic [CNT_W-1:0] chg_cnt
`ifdef KB_ARRAY_PARITY_EN
  ,
  output logic             par
`endif
);

  typedef enum logic [1:0] {
    MODE_KB    = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] ChgMax = {CNT_W{1'b1}};

  mode_e            modeSel;
  logic [WIDTH-1:0] cellQ_q, cellQ_d;
  logic [WIDTH-1:0] effK, effB;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] chg_q, chg_d;
  logic             carry;

  function automatic logic kbCell(input logic cur, input logic kIn, input logic bIn);
    case ({kIn, bIn})
      2'b00:   kbCell = ~cur;
      2'b01:   kbCell = 1'b0;
      2'b10:   kbCell = 1'b1;
      default: kbCell = cur;
    endcase
  endfunction

  assign modeSel = mode_e'(mode);

  // COUNT mode reuses the KB cells: a bit toggles (0,0) only when every lower bit is 1.
  always_comb begin
    effK    = k;
    effB    = b;
    carry   = 1'b1;
    cellQ_d = cellQ_q;
    wrap_d  = 1'b0;
    if (modeSel == MODE_COUNT) begin
      for (int i = 0; i < WIDTH; i++) begin
        effK[i] = ~carry;
        effB[i] = ~carry;
        carry   = carry & cellQ_q[i];
      end
    end
    if (en) begin
      case (modeSel)
        MODE_KB, MODE_COUNT: begin
          for (int i = 0; i < WIDTH; i++) begin
            cellQ_d[i] = kbCell(cellQ_q[i], effK[i], effB[i]);
          end
          wrap_d = (modeSel == MODE_COUNT) && (&cellQ_q);
        end
        MODE_SHIFT: cellQ_d = {cellQ_q[WIDTH-2:0], sin};
        default:    cellQ_d = cellQ_q;
      endcase
    end
  end

  always_comb begin
    chg_d = chg_q;
    if ((cellQ_d != cellQ_q) && (chg_q != ChgMax)) begin
      chg_d = chg_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cellQ_q <= '0;
      wrap_q  <= 1'b0;
      chg_q   <= '0;
    end else begin
      cellQ_q <= cellQ_d;
      wrap_q  <= wrap_d;
      chg_q   <= chg_d;
    end
  end

`ifdef KB_ARRAY_PARITY_EN
  logic par_q;

  // Parity of the post-edge state; with en=0 cellQ_d equals cellQ_q so it holds naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^cellQ_d;
    end
  end

  assign par = par_q;
`endif

  assign q       = cellQ_q;
  assign z       = ~(cellQ_q[WIDTH-2:0] ^ cellQ_q[WIDTH-1:1]);
  assign wrap    = wrap_q;
  assign chg_cnt = chg_q;

endmodule

// File: tb/tb_kb_array.sv
// tb_kb_array: directed self-checking bench for kb_array at WIDTH=4, with a CNT_W=2 copy for saturation.
// Parity checks are compiled in when KB_ARRAY_PARITY_EN is defined.
module tb_kb_array;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] k;
  logic [3:0] b;
  logic       sin;
  logic [3:0] q, qSat;
  logic [2:0] z, zSat;
  logic       wrap, wrapSat;
  logic [7:0] chgCnt;
  logic [1:0] chgSat;
`ifdef KB_ARRAY_PARITY_EN
  logic       par, parSat;
`endif

  int total;
  int bad;

  kb_array #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .k(k), .b(b), .sin(sin),
    .q(q), .z(z), .wrap(wrap), .chg_cnt(chgCnt)
`ifdef KB_ARRAY_PARITY_EN
    , .par(par)
`endif
  );

  kb_array #(.WIDTH(4), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .k(k), .b(b), .sin(sin),
    .q(qSat), .z(zSat), .wrap(wrapSat), .chg_cnt(chgSat)
`ifdef KB_ARRAY_PARITY_EN
    , .par(parSat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    en = 1'b1; mode = 2'b00; k = 4'b1111; b = 4'b1111; sin = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; k = '0; b = '0; sin = 1'b0;
    #2;
    total++; if (q !== 4'b0000) begin bad++; $display("[TB] FAIL reset_init_q got=%b want=0000", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL reset_init_wrap got=%b want=0", wrap); end
    total++; if (chgCnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_init_chg got=%0d want=0", chgCnt); end
    doReset();
    mode = 2'b10;
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin = 1'b1; tick();
    total++; if (q !== 4'b1011) begin bad++; $display("[TB] FAIL reset_pre_q got=%b want=1011", q); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (q !== 4'b0000) begin bad++; $display("[TB] FAIL reset_async_q got=%b want=0000", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL reset_async_wrap got=%b want=0", wrap); end
    total++; if (chgCnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_async_chg got=%0d want=0", chgCnt); end
    rst = 1'b0;
  endtask

  task automatic test_kb();
    doReset();
    mode = 2'b00; k = 4'b0100; b = 4'b0010; tick();
    total++; if (q !== 4'b1101) begin bad++; $display("[TB] FAIL kb_mix_q got=%b want=1101", q); end
    total++; if (chgCnt !== 8'd1) begin bad++; $display("[TB] FAIL kb_mix_chg got=%0d want=1", chgCnt); end
    k = 4'b1111; b = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    total++; if (q !== 4'b1101) begin bad++; $display("[TB] FAIL kb_hold_q got=%b want=1101", q); end
    total++; if (chgCnt !== 8'd1) begin bad++; $display("[TB] FAIL kb_hold_chg got=%0d want=1", chgCnt); end
    k = 4'b0000; b = 4'b0000; tick();
    total++; if (q !== 4'b0010) begin bad++; $display("[TB] FAIL kb_toggle1_q got=%b want=0010", q); end
    tick();
    total++; if (q !== 4'b1101) begin bad++; $display("[TB] FAIL kb_toggle2_q got=%b want=1101", q); end
    total++; if (chgCnt !== 8'd3) begin bad++; $display("[TB] FAIL kb_toggle_chg got=%0d want=3", chgCnt); end
    k = 4'b1111; b = 4'b0000; tick();
    total++; if (q !== 4'b1111) begin bad++; $display("[TB] FAIL kb_set_q got=%b want=1111", q); end
    tick();
    total++; if (chgCnt !== 8'd4) begin bad++; $display("[TB] FAIL kb_set_nochange_chg got=%0d want=4", chgCnt); end
    k = 4'b0000; b = 4'b0000; en = 1'b0; tick();
    total++; if (q !== 4'b1111) begin bad++; $display("[TB] FAIL kb_en0_q got=%b want=1111", q); end
    total++; if (chgCnt !== 8'd4) begin bad++; $display("[TB] FAIL kb_en0_chg got=%0d want=4", chgCnt); end
    k = 4'b0000; b = 4'b1111; en = 1'b1; tick();
    total++; if (q !== 4'b0000) begin bad++; $display("[TB] FAIL kb_clear_q got=%b want=0000", q); end
  endtask

  task automatic test_count();
    doReset();
    mode = 2'b00; k = 4'b1110; b = 4'b0001; tick();
    total++; if (q !== 4'b1110) begin bad++; $display("[TB] FAIL cnt_preload_q got=%b want=1110", q); end
    mode = 2'b01; k = 4'b0101; b = 4'b1010; tick();
    total++; if (q !== 4'b1111) begin bad++; $display("[TB] FAIL cnt_e1_q got=%b want=1111", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL cnt_e1_wrap got=%b want=0", wrap); end
    tick();
    total++; if (q !== 4'b0000) begin bad++; $display("[TB] FAIL cnt_e2_q got=%b want=0000", q); end
    total++; if (wrap !== 1'b1) begin bad++; $display("[TB] FAIL cnt_e2_wrap got=%b want=1", wrap); end
    tick();
    total++; if (q !== 4'b0001) begin bad++; $display("[TB] FAIL cnt_e3_q got=%b want=0001", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL cnt_e3_wrap got=%b want=0", wrap); end
    total++; if (z !== 3'b110) begin bad++; $display("[TB] FAIL cnt_e3_z got=%b want=110", z); end
    total++; if (chgCnt !== 8'd4) begin bad++; $display("[TB] FAIL cnt_chg got=%0d want=4", chgCnt); end
    mode = 2'b00; k = 4'b1111; b = 4'b0000; tick();
    mode = 2'b01; en = 1'b0; tick();
    total++; if (q !== 4'b1111) begin bad++; $display("[TB] FAIL cnt_en0_q got=%b want=1111", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL cnt_en0_wrap got=%b want=0", wrap); end
    en = 1'b1; tick();
    total++; if (wrap !== 1'b1) begin bad++; $display("[TB] FAIL cnt_late_wrap got=%b want=1", wrap); end
    en = 1'b0; tick();
    total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL cnt_en0_wrapclr got=%b want=0", wrap); end
    total++; if (chgCnt !== 8'd6) begin bad++; $display("[TB] FAIL cnt_chg2 got=%0d want=6", chgCnt); end
    en = 1'b1; mode = 2'b00; k = 4'b1111; b = 4'b0000; tick();
    mode = 2'b01; tick();
    rst = 1'b1;
    #1;
    total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL cnt_rst_wrap got=%b want=0", wrap); end
    rst = 1'b0;
  endtask

  task automatic test_shift();
    logic [3:0] expQ [4];
    logic       sinSeq [4];
    expQ[0] = 4'b0001; expQ[1] = 4'b0010; expQ[2] = 4'b0101; expQ[3] = 4'b1011;
    sinSeq[0] = 1'b1; sinSeq[1] = 1'b0; sinSeq[2] = 1'b1; sinSeq[3] = 1'b1;
    doReset();
    mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      sin = sinSeq[i]; tick();
      total++; if (q !== expQ[i]) begin bad++; $display("[TB] FAIL shift_step%0d got=%b want=%b", i, q, expQ[i]); end
    end
    total++; if (z !== 3'b001) begin bad++; $display("[TB] FAIL shift_z got=%b want=001", z); end
    mode = 2'b11; sin = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++; if (q !== 4'b1011) begin bad++; $display("[TB] FAIL hold_q got=%b want=1011", q); end
    total++; if (chgCnt !== 8'd4) begin bad++; $display("[TB] FAIL hold_chg got=%0d want=4", chgCnt); end
    mode = 2'b01; tick();
    total++; if (q !== 4'b1100) begin bad++; $display("[TB] FAIL switch_count_q got=%b want=1100", q); end
  endtask

  task automatic test_saturate();
    logic expPar [6];
    expPar[0] = 1'b1; expPar[1] = 1'b1; expPar[2] = 1'b0;
    expPar[3] = 1'b1; expPar[4] = 1'b0; expPar[5] = 1'b0;
    doReset();
    mode = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) begin
        total++; if (chgSat !== 2'd3) begin bad++; $display("[TB] FAIL sat_reach got=%0d want=3", chgSat); end
      end
`ifdef KB_ARRAY_PARITY_EN
      total++; if (par !== expPar[i]) begin bad++; $display("[TB] FAIL par_step%0d got=%b want=%b", i, par, expPar[i]); end
`endif
    end
    total++; if (qSat !== 4'b0110) begin bad++; $display("[TB] FAIL sat_q got=%b want=0110", qSat); end
    total++; if (zSat !== 3'b010) begin bad++; $display("[TB] FAIL sat_z got=%b want=010", zSat); end
    total++; if (wrapSat !== 1'b0) begin bad++; $display("[TB] FAIL sat_wrap got=%b want=0", wrapSat); end
    total++; if (chgSat !== 2'd3) begin bad++; $display("[TB] FAIL sat_hold got=%0d want=3", chgSat); end
    total++; if (chgCnt !== 8'd6) begin bad++; $display("[TB] FAIL sat_wide got=%0d want=6", chgCnt); end
`ifdef KB_ARRAY_PARITY_EN
    en = 1'b0; tick();
    total++; if (parSat !== 1'b0) begin bad++; $display("[TB] FAIL par_en0 got=%b want=0", parSat); end
    rst = 1'b1; en = 1'b1; mode = 2'b00; k = 4'b1111; b = 4'b0000;
    #1;
    total++; if (par !== 1'b0) begin bad++; $display("[TB] FAIL par_reset got=%b want=0", par); end
    rst = 1'b0; tick();
    total++; if (par !== 1'b0) begin bad++; $display("[TB] FAIL par_all_ones got=%b want=0", par); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_kb();
    test_count();
    test_shift();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
